// File: rtl/fpu.sv
// fpu: multi-cycle binary32 add/sub/mul/div with round-to-nearest-even.
// Subnormal inputs read as signed zero and subnormal results flush to signed zero.
module fpu #(
  parameter int unsigned PRECISION = 32
) (
  input  logic [PRECISION-1:0] A,
  input  logic [PRECISION-1:0] B,
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [1:0]           Operation,
  output logic [PRECISION-1:0] Result,
  output logic                 Done
);
  localparam int unsigned MW = 24;  // mantissa including hidden bit
  localparam int unsigned NW = 27;  // normalised mantissa + guard, round, sticky
  localparam int unsigned PW = 48;  // product / working register width
  localparam int unsigned RW = 26;  // divider remainder width
  localparam int unsigned EW = 11;  // signed working exponent
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_CALC, S_NORM, S_ROUND, S_DONE} state_t;

  state_t              state;
  logic [31:0]         a_r, b_r;
  logic [1:0]          op_r;
  logic                sa_r, sb_r, sign_r, zero_r;
  logic [7:0]          ea_r, eb_r;
  logic [MW-1:0]       ma_r, mb_r;
  logic [PW-1:0]       work_r;
  logic [RW-1:0]       rem_r;
  logic [4:0]          cnt_r;
  logic signed [EW-1:0] exp_r;
  logic [NW-1:0]       m_r;

  // Operand fields of the captured inputs; subtraction flips the sign of B
  logic [7:0]    ea, eb;
  logic [MW-1:0] ma, mb;
  logic          sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign ea     = a_r[30:23];
  assign eb     = b_r[30:23];
  assign ma     = (ea == 8'd0) ? '0 : {1'b1, a_r[22:0]};
  assign mb     = (eb == 8'd0) ? '0 : {1'b1, b_r[22:0]};
  assign sa     = a_r[31];
  assign sb     = b_r[31] ^ (op_r == 2'b01);
  assign a_nan  = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);

  // Special operands that resolve without arithmetic
  logic        spec_hit, smd;
  logic [31:0] spec_res;
  always_comb begin
    spec_hit = 1'b1;
    spec_res = QNAN;
    smd      = a_r[31] ^ b_r[31];
    if (a_nan || b_nan) begin
      spec_res = QNAN;
    end else begin
      case (op_r)
        2'b10: begin
          if (a_inf || b_inf)        spec_res = (a_zero || b_zero) ? QNAN : {smd, 8'hFF, 23'd0};
          else if (a_zero || b_zero) spec_res = {smd, 31'd0};
          else                       spec_hit = 1'b0;
        end
        2'b11: begin
          if ((a_inf && b_inf) || (a_zero && b_zero)) spec_res = QNAN;
          else if (a_inf || b_zero)                   spec_res = {smd, 8'hFF, 23'd0};
          else if (b_inf || a_zero)                   spec_res = {smd, 31'd0};
          else                                        spec_hit = 1'b0;
        end
        default: begin
          if (a_inf && b_inf) spec_res = (sa == sb) ? {sa, 8'hFF, 23'd0} : QNAN;
          else if (a_inf)     spec_res = {sa, 8'hFF, 23'd0};
          else if (b_inf)     spec_res = {sb, 8'hFF, 23'd0};
          else                spec_hit = 1'b0;
        end
      endcase
    end
  end

  // Add/sub: align the smaller magnitude with sticky, then add or subtract
  logic          a_big, big_s, small_s;
  logic [7:0]    big_e, small_e, d;
  logic [MW-1:0] big_m, small_m;
  logic [NW-1:0] xs, sh;
  logic [NW:0]   sum;
  always_comb begin
    a_big   = (ea_r > eb_r) || ((ea_r == eb_r) && (ma_r >= mb_r));
    big_e   = a_big ? ea_r : eb_r;
    small_e = a_big ? eb_r : ea_r;
    big_m   = a_big ? ma_r : mb_r;
    small_m = a_big ? mb_r : ma_r;
    big_s   = a_big ? sa_r : sb_r;
    small_s = a_big ? sb_r : sa_r;
    d       = big_e - small_e;
    xs      = {small_m, 3'b000};
    if (d >= 8'd27) begin
      sh = {26'd0, |xs};
    end else begin
      sh    = xs >> d;
      sh[0] = sh[0] | (|(xs & ~({NW{1'b1}} << d)));
    end
    if (big_s == small_s) sum = {1'b0, big_m, 3'b000} + {1'b0, sh};
    else                  sum = {1'b0, big_m, 3'b000} - {1'b0, sh};
  end

  // Normalise to a leading one at bit NW-1
  logic [4:0]           lz;
  logic [NW-1:0]        norm_m;
  logic signed [EW-1:0] norm_e;
  logic                 norm_zero;
  always_comb begin
    lz        = '0;
    for (int i = 0; i < NW; i++) if (work_r[i]) lz = 5'(NW - 1 - i);
    norm_m    = '0;
    norm_e    = exp_r;
    norm_zero = 1'b0;
    case (op_r)
      2'b10: begin
        if (work_r[47]) begin
          norm_m = {work_r[47:22], |work_r[21:0]};
          norm_e = exp_r + 11'sd1;
        end else begin
          norm_m = {work_r[46:21], |work_r[20:0]};
        end
      end
      2'b11: begin
        if (work_r[25]) begin
          norm_m = {work_r[25:0], |rem_r};
        end else begin
          norm_m = {work_r[24:0], 1'b0, |rem_r};
          norm_e = exp_r - 11'sd1;
        end
      end
      default: begin
        if (work_r[27:0] == 28'd0) begin
          norm_zero = 1'b1;
        end else if (work_r[27]) begin
          norm_m = {work_r[27:2], |work_r[1:0]};
          norm_e = exp_r + 11'sd1;
        end else begin
          norm_m = work_r[26:0] << lz;
          norm_e = exp_r - $signed({6'd0, lz});
        end
      end
    endcase
  end

  // Round to nearest even, renormalise on carry, then range-check
  logic                 rnd_up;
  logic [MW:0]          mr;
  logic signed [EW-1:0] re;
  logic [22:0]          rfrac;
  logic [31:0]          rres;
  always_comb begin
    rnd_up = m_r[2] & (m_r[3] | m_r[1] | m_r[0]);
    mr     = {1'b0, m_r[26:3]} + 25'(rnd_up);
    re     = mr[24] ? exp_r + 11'sd1 : exp_r;
    rfrac  = mr[24] ? mr[23:1] : mr[22:0];
    if (zero_r || (re <= 11'sd0)) rres = {sign_r, 31'd0};
    else if (re >= 11'sd255)      rres = {sign_r, 8'hFF, 23'd0};
    else                          rres = {sign_r, re[7:0], rfrac};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= '0;
      sa_r   <= 1'b0;
      sb_r   <= 1'b0;
      sign_r <= 1'b0;
      zero_r <= 1'b0;
      ea_r   <= '0;
      eb_r   <= '0;
      ma_r   <= '0;
      mb_r   <= '0;
      work_r <= '0;
      rem_r  <= '0;
      cnt_r  <= '0;
      exp_r  <= '0;
      m_r    <= '0;
      Result <= '0;
      Done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          a_r   <= A[31:0];
          b_r   <= B[31:0];
          op_r  <= Operation;
          state <= S_UNPACK;
        end
        S_UNPACK: begin
          if (spec_hit) begin
            Result <= PRECISION'(spec_res);
            Done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            sa_r   <= sa;
            sb_r   <= sb;
            ea_r   <= ea;
            eb_r   <= eb;
            ma_r   <= ma;
            mb_r   <= mb;
            sign_r <= a_r[31] ^ b_r[31];
            work_r <= '0;
            rem_r  <= RW'(ma);
            cnt_r  <= '0;
            if (op_r == 2'b10)      exp_r <= 11'(ea) + 11'(eb) - 11'sd127;
            else if (op_r == 2'b11) exp_r <= 11'(ea) - 11'(eb) + 11'sd127;
            else                    exp_r <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          cnt_r <= cnt_r + 5'd1;
          case (op_r)
            2'b10: begin
              if (mb_r[cnt_r]) work_r <= work_r + (PW'(ma_r) << cnt_r);
              if (cnt_r == 5'd23) state <= S_NORM;
            end
            2'b11: begin
              if (rem_r >= RW'(mb_r)) begin
                rem_r  <= (rem_r - RW'(mb_r)) << 1;
                work_r <= {work_r[PW-2:0], 1'b1};
              end else begin
                rem_r  <= rem_r << 1;
                work_r <= {work_r[PW-2:0], 1'b0};
              end
              if (cnt_r == 5'd25) state <= S_NORM;
            end
            default: begin
              work_r <= PW'(sum);
              sign_r <= big_s;
              exp_r  <= $signed({3'd0, big_e});
              state  <= S_NORM;
            end
          endcase
        end
        S_NORM: begin
          m_r    <= norm_m;
          exp_r  <= norm_e;
          zero_r <= norm_zero;
          if (norm_zero) sign_r <= sa_r & sb_r;
          state  <= S_ROUND;
        end
        S_ROUND: begin
          Result <= PRECISION'(rres);
          Done   <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu.sv
// Directed self-checking bench for fpu: arithmetic, specials, rounding, range and reset behaviour.
module tb_fpu;
  logic [31:0] A, B, Result;
  logic        Clk, Reset, Done;
  logic [1:0]  Operation;
  int          checks, errors;

  fpu #(.PRECISION(32)) dut (
    .A(A), .B(B), .Clk(Clk), .Reset(Reset),
    .Operation(Operation), .Result(Result), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reset, load operands, release and wait (bounded) for Done; lat=99 on timeout
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        output logic [31:0] res, output int lat);
    @(negedge Clk);
    Reset = 1'b0;
    A = a; B = b; Operation = op;
    #2;
    Reset = 1'b1;
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk); #1;
      if (Done) begin
        lat = i;
        break;
      end
    end
    res = Result;
  endtask

  // Run a list of vectors, check each result and its latency bound
  task automatic run_table(input string name, input logic [31:0] va[], input logic [31:0] vb[],
                           input logic [1:0] vo[], input logic [31:0] ve[], input int lim);
    logic [31:0] r;
    int          lat;
    for (int i = 0; i < va.size(); i++) begin
      run_op(va[i], vb[i], vo[i], r, lat);
      checks++;
      if (r !== ve[i]) begin
        $display("FAIL %s[%0d] result got %h want %h", name, i, r, ve[i]);
        errors++;
      end
      checks++;
      if (lat > lim) begin
        $display("FAIL %s[%0d] latency got %0d want <= %0d", name, i, lat, lim);
        errors++;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b0;
    A = 32'h3F80_0000; B = 32'h3F80_0000; Operation = 2'b00;
    #1;
    checks++;
    if (Result !== 32'h0) begin
      $display("FAIL reset_result got %h want 00000000", Result);
      errors++;
    end
    checks++;
    if (Done !== 1'b0) begin
      $display("FAIL reset_done got %b want 0", Done);
      errors++;
    end
  endtask

  task automatic test_add_sub();
    logic [31:0] va[] = '{32'h0000_0000, 32'h3FC0_0000, 32'h0000_0000, 32'h3FC0_0000,
                          32'h8000_0000, 32'h3F80_0000, 32'hC000_0000};
    logic [31:0] vb[] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4100_0000, 32'h3FC0_0000,
                          32'h8000_0000, 32'h3F7F_FFFF, 32'h3F80_0000};
    logic [1:0]  vo[] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
    logic [31:0] ve[] = '{32'h3F80_0000, 32'h4040_0000, 32'hC100_0000, 32'h0000_0000,
                          32'h8000_0000, 32'h3380_0000, 32'hBF80_0000};
    run_table("addsub", va, vb, vo, ve, 8);
  endtask

  task automatic test_mul();
    logic [31:0] va[] = '{32'h0000_0000, 32'h3FC0_0000, 32'h7F00_0000, 32'h4000_0000,
                          32'h0080_0000, 32'hC040_0000};
    logic [31:0] vb[] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000,
                          32'h3F00_0000, 32'h4000_0000};
    logic [1:0]  vo[] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [31:0] ve[] = '{32'h0000_0000, 32'h4010_0000, 32'h7F80_0000, 32'h40C0_0000,
                          32'h0000_0000, 32'hC0C0_0000};
    run_table("mul", va, vb, vo, ve, 30);
  endtask

  task automatic test_div();
    logic [31:0] va[] = '{32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000,
                          32'h40C0_0000, 32'hBF80_0000};
    logic [31:0] vb[] = '{32'h3F80_0000, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000,
                          32'h4000_0000, 32'h0000_0000};
    logic [1:0]  vo[] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [31:0] ve[] = '{32'h0000_0000, 32'h3EAA_AAAB, 32'h7F80_0000, 32'h7FC0_0000,
                          32'h4040_0000, 32'hFF80_0000};
    run_table("div", va, vb, vo, ve, 32);
  endtask

  task automatic test_rounding();
    logic [31:0] va[] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0001};
    logic [31:0] vb[] = '{32'h3380_0000, 32'h3380_0001, 32'h3380_0000};
    logic [1:0]  vo[] = '{2'b00, 2'b00, 2'b00};
    logic [31:0] ve[] = '{32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0002};
    run_table("round", va, vb, vo, ve, 8);
  endtask

  task automatic test_specials();
    logic [31:0] va[] = '{32'h7FC0_0001, 32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000,
                          32'h3F80_0000, 32'hFF80_0000};
    logic [31:0] vb[] = '{32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000,
                          32'h7F80_0000, 32'h3F80_0000};
    logic [1:0]  vo[] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
    logic [31:0] ve[] = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                          32'h0000_0000, 32'hFF80_0000};
    run_table("special", va, vb, vo, ve, 3);
  endtask

  task automatic test_hold();
    logic [31:0] r;
    int          lat;
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 2'b10, r, lat);
    A = 32'h4100_0000; B = 32'h4100_0000; Operation = 2'b00;
    repeat (6) @(posedge Clk);
    #1;
    checks++;
    if (Result !== 32'h4010_0000) begin
      $display("FAIL hold_result got %h want 40100000", Result);
      errors++;
    end
    checks++;
    if (Done !== 1'b1) begin
      $display("FAIL hold_done got %b want 1", Done);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int          lat;
    @(negedge Clk);
    Reset = 1'b0;
    A = 32'h3F80_0000; B = 32'h4040_0000; Operation = 2'b11;
    #2;
    Reset = 1'b1;
    repeat (10) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (Result !== 32'h0) begin
      $display("FAIL mid_reset_result got %h want 00000000", Result);
      errors++;
    end
    checks++;
    if (Done !== 1'b0) begin
      $display("FAIL mid_reset_done got %b want 0", Done);
      errors++;
    end
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 2'b00, r, lat);
    checks++;
    if (r !== 32'h4040_0000) begin
      $display("FAIL mid_reset_rerun got %h want 40400000", r);
      errors++;
    end
    checks++;
    if (Done !== 1'b1) begin
      $display("FAIL mid_reset_rerun_done got %b want 1", Done);
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b0;
    A = '0; B = '0; Operation = 2'b00;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_rounding();
    test_specials();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu.md
# fpu

Multi-cycle IEEE-754 single-precision floating-point unit: add, subtract, multiply and divide two operands, one operation per reset-release. It is a standalone arithmetic block. A controller loads operands and an opcode, releases reset, and waits for `Done`. Results are bit-exact to IEEE-754 binary32 with round-to-nearest-even, except for the subnormal flush rules below.

## Interface
- `PRECISION`, default 32: operand/result width. Only 32 is supported (8-bit exponent, 23-bit fraction, bias 127).
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset. Low clears all state. A low-to-high transition arms a new operation.
- `A`  in  PRECISION  operand 1 (binary32 bits).
- `B`  in  PRECISION  operand 2 (binary32 bits).
- `Operation`  in  2  opcode: 00 = A+B, 01 = A−B, 10 = A×B, 11 = A÷B.
- `Result`  out  PRECISION  binary32 result. Valid while `Done`=1.
- `Done`  out  1  result-valid flag. Stays high until the next reset.
- Port order for positional instantiation: `A`, `B`, `Clk`, `Reset`, `Operation`, `Result`, `Done`.

## Operation
- States: IDLE → UNPACK → CALC → NORM → ROUND → DONE.
- IDLE: on the first rising edge with `Reset`=1, capture `A`, `B` and `Operation`. Later input changes are ignored until the next reset.
- UNPACK: split sign, exponent and mantissa; restore the hidden 1.
  - Exponent field 0 (zero or subnormal) is treated as signed zero.
  - Exponent 255 is Inf or NaN.
- Specials are resolved in UNPACK and jump straight to DONE:
  - Any NaN operand → 0x7FC00000.
  - Inf−Inf (effective subtraction), 0×Inf, 0÷0, Inf÷Inf → 0x7FC00000.
  - x÷0 (x nonzero) → Inf with sign = sA^sB. Inf÷x → signed Inf. x÷Inf → signed 0.
  - Inf±finite → that Inf. Inf×nonzero → signed Inf.
- Signs of zero results:
  - Add/sub, exact zero sum: +0, except (−0)+(−0) → −0.
  - Mul/div: sign of a zero result = sA^sB.
- Add/sub:
  - Subtract flips the sign of B.
  - Align the smaller-exponent operand by right shift, collecting guard, round and sticky bits. Add or subtract the magnitudes.
- Multiply: 24×24 shift-add, one partial product per cycle. Exponent = eA+eB−127.
- Divide: restoring division, one quotient bit per cycle. Produce 26 bits plus sticky from the remainder. Exponent = eA−eB+127.
- NORM: normalise the mantissa to 1.xxx and adjust the exponent.
- ROUND: round to nearest, ties to even, then renormalise on mantissa carry-out.
- Range handling:
  - Final biased exponent ≥ 255 → signed Inf (0x7F800000 | sign).
  - Final biased exponent ≤ 0 → signed zero (subnormal outputs are flushed).

## Timing
- Reset low (asynchronous): `Result`=0x00000000, `Done`=0, FSM = IDLE. This applies immediately, including mid-operation; any partial work is discarded.
- Latency is counted in rising edges from the capture edge. It is deterministic per operation:
  - Special cases: ≤ 3 edges.
  - Add/sub: ≤ 8 edges.
  - Multiply: ≤ 30 edges.
  - Divide: ≤ 32 edges.
  - Hard bound for every case: `Done` by edge 40.
- `Result` and `Done` update on the same edge. `Result` is stable from then on.
- After `Done`, the FSM holds in DONE; `Clk` and input activity have no effect.
- A new operation requires taking `Reset` low (any duration ≥ 1 ns), then high.

## Test plan
- Add: A=0x00000000 (0.0), B=0x3F800000 (1.0), Op=00 → Result 0x3F800000, `Done` within 40 cycles.
- Sub: A=0.0, B=0x41000000 (8.0), Op=01 → 0xC1000000 (−8.0). Also 1.5−1.5 → 0x00000000 (+0).
- Mul: 0.0×1.0 → 0x00000000. 1.5×1.5 (0x3FC00000 each) → 0x40100000 (2.25). 0x7F000000×0x40000000 → 0x7F800000 (overflow).
- Div: 0.0÷1.0 → 0x00000000. 1.0÷3.0 (0x40400000) → 0x3EAAAAAB (RNE). 1.0÷0.0 → 0x7F800000. 0.0÷0.0 → 0x7FC00000.
- Rounding/alignment: 1.0 + 0x33800000 (2^−24, tie) → 0x3F800000 (ties to even). 1.0 + 0x33800001 → 0x3F800001.
- Reset mid-operation: start a divide, pull `Reset` low at cycle 10 → `Result`=0 and `Done`=0 immediately. Release with Op=00, 1.5+1.5 → 0x40400000 and `Done`=1.
